// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the register-file write side: data width, register
// address width, the x0 address, the writeback record and a one-hot helper
// used to build destination masks.
// ---------------------------------------------------------------------------
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One writeback result: destination, payload and a liveness flag.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_rec_t;

    // One-hot encoding of a register address into a 32-bit mask.
    function automatic logic [31:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        return 32'd1 << rd;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Small queue of M-unit results waiting for the register-file write port.
// Each entry carries a valid bit that can be cleared by destination match
// (write-after-write kill) while the entry stays in the queue; killed
// entries are still popped in order but produce no write.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   enq_i/enq_rd_i/enq_data_i  push a result at the tail
//   deq_i                  pop the head
//   kill_i/kill_rd_i       invalidate every live entry whose rd matches
//   head_valid_o/_rd_o/_data_o  head entry (valid only when occupied and live)
//   count_o                occupancy, including killed entries
//   valid_o                per-slot live bits
//   pending_mask_o         registered OR of one-hot(rd) over live entries
// ---------------------------------------------------------------------------
module wb_fifo
    import rv_pkg::*;
#(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enq_i,
    input  logic [REG_ADDR_W-1:0] enq_rd_i,
    input  logic [XLEN-1:0]       enq_data_i,
    input  logic                  deq_i,
    input  logic                  kill_i,
    input  logic [REG_ADDR_W-1:0] kill_rd_i,
    output logic                  head_valid_o,
    output logic [REG_ADDR_W-1:0] head_rd_o,
    output logic [XLEN-1:0]       head_data_o,
    output logic [CNT_W-1:0]      count_o,
    output logic [DEPTH-1:0]      valid_o,
    output logic [31:0]           pending_mask_o
);

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
    logic [REG_ADDR_W-1:0] rd_d   [DEPTH];
    logic [XLEN-1:0]       data_q [DEPTH];
    logic [XLEN-1:0]       data_d [DEPTH];
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [31:0]           mask_q, mask_d;

    // Next-state: kill first, then pop, then push. The caller never kills
    // and pops in the same cycle, and never pushes into a full queue.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        mask_d  = 32'd0;

        if (kill_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (rd_q[i] == kill_rd_i)) begin
                    valid_d[i] = 1'b0;
                end
            end
        end

        if (deq_i) begin
            valid_d[rdPtr_q] = 1'b0;
            rdPtr_d          = rdPtr_q + PTR_W'(1);
        end

        if (enq_i) begin
            valid_d[wrPtr_q] = 1'b1;
            rd_d[wrPtr_q]    = enq_rd_i;
            data_d[wrPtr_q]  = enq_data_i;
            wrPtr_d          = wrPtr_q + PTR_W'(1);
        end

        if (enq_i && !deq_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (deq_i && !enq_i) begin
            count_d = count_q - CNT_W'(1);
        end

        // Mask is built from next-state so it moves on the same edge as the queue.
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_d[i]) begin
                mask_d = mask_d | rd_onehot(rd_d[i]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            mask_q  <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= REG_ZERO;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            mask_q  <= mask_d;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= rd_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign head_valid_o   = (count_q != '0) && valid_q[rdPtr_q];
    assign head_rd_o      = rd_q[rdPtr_q];
    assign head_data_o    = data_q[rdPtr_q];
    assign count_o        = count_q;
    assign valid_o        = valid_q;
    assign pending_mask_o = mask_q;

endmodule

// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
// Write-side front end of the 32x32 register file. Merges the unstallable
// ALU result path and the valid/ready M-unit path onto one registered
// write port, queueing M results while the ALU owns the port.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data ALU result for this cycle
//   md_valid/md_rd/md_data    M-unit result offer; md_ready accepts it
//   wb_write_register/wb_write_data/wb_regWrite  registered write port
//   pending_mask              destinations held by live queued entries
// ---------------------------------------------------------------------------
module regfile_writeback
    import rv_pkg::*;
#(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [REG_ADDR_W-1:0] md_rd,
    input  logic [XLEN-1:0]       md_data,
    output logic [REG_ADDR_W-1:0] wb_write_register,
    output logic [XLEN-1:0]       wb_write_data,
    output logic                  wb_regWrite,
    output logic [31:0]           pending_mask
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  readyEn_q;
    logic                  wbRegWrite_q, wbRegWrite_d;
    logic [REG_ADDR_W-1:0] wbWriteRegister_q, wbWriteRegister_d;
    logic [XLEN-1:0]       wbWriteData_q, wbWriteData_d;

    logic                  headValid;
    logic [REG_ADDR_W-1:0] headRd;
    logic [XLEN-1:0]       headData;
    logic [CNT_W-1:0]      fifoCount;
    logic [DEPTH-1:0]      fifoValid;

    logic aluUse, accept, deq, headWrite, portFree, bypass, mdKilled, enq;

    // md_ready comes only from registered state; readyEn_q holds it low
    // until the first edge after reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readyEn_q <= 1'b0;
        end else begin
            readyEn_q <= 1'b1;
        end
    end

    assign md_ready = readyEn_q && (fifoCount < CNT_W'(DEPTH));

    assign aluUse    = alu_valid && (alu_rd != REG_ZERO);
    assign accept    = md_valid && md_ready;
    assign deq       = !aluUse && (fifoCount != '0);
    assign headWrite = deq && headValid;
    // Bypass is only allowed when no live entry is queued, so a newer M
    // result can never overtake an older one. Killed leftovers don't count.
    assign portFree  = !aluUse && !(|fifoValid);
    assign bypass    = accept && portFree;
    // An M result arriving alongside a younger ALU write to the same rd is
    // already dead.
    assign mdKilled  = aluUse && (md_rd == alu_rd);
    assign enq       = accept && !bypass && (md_rd != REG_ZERO) && !mdKilled;

    wb_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i          (clk),
        .rst_ni         (rst),
        .enq_i          (enq),
        .enq_rd_i       (md_rd),
        .enq_data_i     (md_data),
        .deq_i          (deq),
        .kill_i         (aluUse),
        .kill_rd_i      (alu_rd),
        .head_valid_o   (headValid),
        .head_rd_o      (headRd),
        .head_data_o    (headData),
        .count_o        (fifoCount),
        .valid_o        (fifoValid),
        .pending_mask_o (pending_mask)
    );

    // Port arbitration: ALU, then queue head, then bypassed M result.
    // Address and data hold when nothing is written.
    always_comb begin
        wbRegWrite_d      = 1'b0;
        wbWriteRegister_d = wbWriteRegister_q;
        wbWriteData_d     = wbWriteData_q;
        if (aluUse) begin
            wbRegWrite_d      = 1'b1;
            wbWriteRegister_d = alu_rd;
            wbWriteData_d     = alu_data;
        end else if (headWrite) begin
            wbRegWrite_d      = 1'b1;
            wbWriteRegister_d = headRd;
            wbWriteData_d     = headData;
        end else if (bypass && (md_rd != REG_ZERO)) begin
            wbRegWrite_d      = 1'b1;
            wbWriteRegister_d = md_rd;
            wbWriteData_d     = md_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbRegWrite_q      <= 1'b0;
            wbWriteRegister_q <= REG_ZERO;
            wbWriteData_q     <= '0;
        end else begin
            wbRegWrite_q      <= wbRegWrite_d;
            wbWriteRegister_q <= wbWriteRegister_d;
            wbWriteData_q     <= wbWriteData_d;
        end
    end

    assign wb_regWrite       = wbRegWrite_q;
    assign wb_write_register = wbWriteRegister_q;
    assign wb_write_data     = wbWriteData_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback
// Directed scenario tasks with hand-computed expectations, followed by a
// randomized run checked against a small queue model.
// ---------------------------------------------------------------------------
module tb_regfile_writeback;
    import rv_pkg::*;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic [4:0]  wb_write_register;
    logic [31:0] wb_write_data;
    logic        wb_regWrite;
    logic [31:0] pending_mask;

    int checks   = 0;
    int failures = 0;

    regfile_writeback #(.XLEN(32), .DEPTH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .alu_valid         (alu_valid),
        .alu_rd            (alu_rd),
        .alu_data          (alu_data),
        .md_valid          (md_valid),
        .md_ready          (md_ready),
        .md_rd             (md_rd),
        .md_data           (md_data),
        .wb_write_register (wb_write_register),
        .wb_write_data     (wb_write_data),
        .wb_regWrite       (wb_regWrite),
        .pending_mask      (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs.
    task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] mr, input logic [31:0] md);
        alu_valid = av;
        alu_rd    = ar;
        alu_data  = ad;
        md_valid  = mv;
        md_rd     = mr;
        md_data   = md;
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        checks++; if (wb_regWrite !== 1'b0) begin failures++; $display("[TB] FAIL reset_we got=%0b want=0", wb_regWrite); end
        checks++; if (wb_write_register !== 5'd0) begin failures++; $display("[TB] FAIL reset_reg got=%0d want=0", wb_write_register); end
        checks++; if (wb_write_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_data got=%h want=0", wb_write_data); end
        checks++; if (pending_mask !== 32'd0) begin failures++; $display("[TB] FAIL reset_mask got=%h want=0", pending_mask); end
        checks++; if (md_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%0b want=0", md_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (md_ready !== 1'b0) begin failures++; $display("[TB] FAIL ready_before_edge got=%0b want=0", md_ready); end
        stepCycle();
        checks++; if (md_ready !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_edge got=%0b want=1", md_ready); end
        checks++; if (wb_regWrite !== 1'b0) begin failures++; $display("[TB] FAIL idle_we got=%0b want=0", wb_regWrite); end
    endtask

    task automatic test_alu_only();
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        stepCycle();
        checks++; if (wb_regWrite !== 1'b1) begin failures++; $display("[TB] FAIL alu_we got=%0b want=1", wb_regWrite); end
        checks++; if (wb_write_register !== 5'd5) begin failures++; $display("[TB] FAIL alu_reg got=%0d want=5", wb_write_register); end
        checks++; if (wb_write_data !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL alu_data got=%h want=deadbeef", wb_write_data); end
        applyStimulus(1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'd0);
        stepCycle();
        checks++; if (wb_regWrite !== 1'b0) begin failures++; $display("[TB] FAIL alu_x0_we got=%0b want=0", wb_regWrite); end
        checks++; if (wb_write_register !== 5'd5) begin failures++; $display("[TB] FAIL hold_reg got=%0d want=5", wb_write_register); end
        checks++; if (wb_write_data !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL hold_data got=%h want=deadbeef", wb_write_data); end
    endtask

    task automatic test_bypass();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);
        #1;
        checks++; if (md_ready !== 1'b1) begin failures++; $display("[TB] FAIL bypass_ready got=%0b want=1", md_ready); end
        stepCycle();
        checks++; if (wb_regWrite !== 1'b1) begin failures++; $display("[TB] FAIL bypass_we got=%0b want=1", wb_regWrite); end
        checks++; if (wb_write_register !== 5'd7) begin failures++; $display("[TB] FAIL bypass_reg got=%0d want=7", wb_write_register); end
        checks++; if (wb_write_data !== 32'h12345678) begin failures++; $display("[TB] FAIL bypass_data got=%h want=12345678", wb_write_data); end
        checks++; if (pending_mask !== 32'd0) begin failures++; $display("[TB] FAIL bypass_mask got=%h want=0", pending_mask); end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        stepCycle();
        checks++; if (wb_regWrite !== 1'b0) begin failures++; $display("[TB] FAIL bypass_idle_we got=%0b want=0", wb_regWrite); end
    endtask

    task automatic test_contention();
        applyStimulus(1'b1, 5'd1, 32'h101, 1'b1, 5'd9, 32'h900);
        stepCycle();
        checks++; if (pending_mask !== 32'h200) begin failures++; $display("[TB] FAIL cont_mask1 got=%h want=200", pending_mask); end
        applyStimulus(1'b1, 5'd2, 32'h102, 1'b1, 5'd10, 32'hA00);
        stepCycle();
        checks++; if (wb_write_register !== 5'd2) begin failures++; $display("[TB] FAIL cont_reg2 got=%0d want=2", wb_write_register); end
        applyStimulus(1'b1, 5'd3, 32'h103, 1'b0, 5'd0, 32'd0);
        stepCycle();
        applyStimulus(1'b1, 5'd4, 32'h104, 1'b0, 5'd0, 32'd0);
        stepCycle();
        checks++; if (wb_write_data !== 32'h104) begin failures++; $display("[TB] FAIL cont_data4 got=%h want=104", wb_write_data); end
        checks++; if (pending_mask !== 32'h600) begin failures++; $display("[TB] FAIL cont_mask_full got=%h want=600", pending_mask); end
        checks++; if (md_ready !== 1'b0) begin failures++; $display("[TB] FAIL cont_ready_full got=%0b want=0", md_ready); end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        stepCycle();
        checks++; if (wb_regWrite !== 1'b1 || wb_write_register !== 5'd9 || wb_write_data !== 32'h900) begin
            failures++; $display("[TB] FAIL drain_x9 got we=%0b reg=%0d data=%h want we=1 reg=9 data=900", wb_regWrite, wb_write_register, wb_write_data); end
        checks++; if (md_ready !== 1'b1) begin failures++; $display("[TB] FAIL drain_ready got=%0b want=1", md_ready); end
        stepCycle();
        checks++; if (wb_regWrite !== 1'b1 || wb_write_register !== 5'd10 || wb_write_data !== 32'hA00) begin
            failures++; $display("[TB] FAIL drain_x10 got we=%0b reg=%0d data=%h want we=1 reg=10 data=a00", wb_regWrite, wb_write_register, wb_write_data); end
        checks++; if (pending_mask !== 32'd0) begin failures++; $display("[TB] FAIL drain_mask got=%h want=0", pending_mask); end
        stepCycle();
        checks++; if (wb_regWrite !== 1'b0) begin failures++; $display("[TB] FAIL drain_idle got=%0b want=0", wb_regWrite); end
    endtask

    task automatic test_waw_kill();
        applyStimulus(1'b1, 5'd3, 32'h3, 1'b1, 5'd9, 32'h999);
        stepCycle();
        checks++; if (pending_mask !== 32'h200) begin failures++; $display("[TB] FAIL kill_pre_mask got=%h want=200", pending_mask); end
        applyStimulus(1'b1, 5'd9, 32'hAAAA, 1'b0, 5'd0, 32'd0);
        stepCycle();
        checks++; if (wb_regWrite !== 1'b1 || wb_write_register !== 5'd9 || wb_write_data !== 32'hAAAA) begin
            failures++; $display("[TB] FAIL kill_alu got we=%0b reg=%0d data=%h want we=1 reg=9 data=aaaa", wb_regWrite, wb_write_register, wb_write_data); end
        checks++; if (pending_mask !== 32'd0) begin failures++; $display("[TB] FAIL kill_mask got=%h want=0", pending_mask); end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        stepCycle();
        checks++; if (wb_regWrite !== 1'b0) begin failures++; $display("[TB] FAIL kill_no_x9 got=%0b want=0", wb_regWrite); end
        checks++; if (wb_write_data !== 32'hAAAA) begin failures++; $display("[TB] FAIL kill_hold got=%h want=aaaa", wb_write_data); end
        // Killed head leaves the port free for a bypass in the same cycle.
        applyStimulus(1'b1, 5'd3, 32'h3, 1'b1, 5'd9, 32'h999);
        stepCycle();
        applyStimulus(1'b1, 5'd9, 32'hBBBB, 1'b0, 5'd0, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0C0);
        #1;
        checks++; if (md_ready !== 1'b1) begin failures++; $display("[TB] FAIL kill_byp_ready got=%0b want=1", md_ready); end
        stepCycle();
        checks++; if (wb_regWrite !== 1'b1 || wb_write_register !== 5'd12 || wb_write_data !== 32'hC0C0) begin
            failures++; $display("[TB] FAIL kill_bypass got we=%0b reg=%0d data=%h want we=1 reg=12 data=c0c0", wb_regWrite, wb_write_register, wb_write_data); end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        stepCycle();
    endtask

    task automatic test_full_simultaneous();
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h9);
        stepCycle();
        applyStimulus(1'b1, 5'd2, 32'h2, 1'b1, 5'd10, 32'hA);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB);
        #1;
        checks++; if (md_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got=%0b want=0", md_ready); end
        stepCycle();
        checks++; if (wb_regWrite !== 1'b1 || wb_write_register !== 5'd9) begin
            failures++; $display("[TB] FAIL full_deq got we=%0b reg=%0d want we=1 reg=9", wb_regWrite, wb_write_register); end
        checks++; if (md_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_back got=%0b want=1", md_ready); end
        checks++; if (pending_mask !== 32'h400) begin failures++; $display("[TB] FAIL full_mask1 got=%h want=400", pending_mask); end
        stepCycle();
        checks++; if (wb_regWrite !== 1'b1 || wb_write_register !== 5'd10 || wb_write_data !== 32'hA) begin
            failures++; $display("[TB] FAIL full_x10 got we=%0b reg=%0d data=%h want we=1 reg=10 data=a", wb_regWrite, wb_write_register, wb_write_data); end
        checks++; if (pending_mask !== 32'h800) begin failures++; $display("[TB] FAIL full_mask2 got=%h want=800", pending_mask); end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        stepCycle();
        checks++; if (wb_regWrite !== 1'b1 || wb_write_register !== 5'd11 || wb_write_data !== 32'hB) begin
            failures++; $display("[TB] FAIL full_x11 got we=%0b reg=%0d data=%h want we=1 reg=11 data=b", wb_regWrite, wb_write_register, wb_write_data); end
        stepCycle();
    endtask

    task automatic test_reset_midop();
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h9);
        stepCycle();
        applyStimulus(1'b1, 5'd2, 32'h2, 1'b1, 5'd10, 32'hA);
        stepCycle();
        checks++; if (pending_mask !== 32'h600) begin failures++; $display("[TB] FAIL midrst_pre_mask got=%h want=600", pending_mask); end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (wb_regWrite !== 1'b0) begin failures++; $display("[TB] FAIL midrst_we got=%0b want=0", wb_regWrite); end
        checks++; if (pending_mask !== 32'd0) begin failures++; $display("[TB] FAIL midrst_mask got=%h want=0", pending_mask); end
        checks++; if (md_ready !== 1'b0) begin failures++; $display("[TB] FAIL midrst_ready got=%0b want=0", md_ready); end
        checks++; if (wb_write_register !== 5'd0 || wb_write_data !== 32'd0) begin
            failures++; $display("[TB] FAIL midrst_port got reg=%0d data=%h want reg=0 data=0", wb_write_register, wb_write_data); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (md_ready !== 1'b0) begin failures++; $display("[TB] FAIL midrst_ready_rel got=%0b want=0", md_ready); end
        stepCycle();
        checks++; if (md_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_ready_up got=%0b want=1", md_ready); end
        checks++; if (wb_regWrite !== 1'b0) begin failures++; $display("[TB] FAIL midrst_lost1 got=%0b want=0", wb_regWrite); end
        stepCycle();
        checks++; if (wb_regWrite !== 1'b0) begin failures++; $display("[TB] FAIL midrst_lost2 got=%0b want=0", wb_regWrite); end
    endtask

    // Randomized traffic against a reference queue model. Starts from an
    // empty queue with the port address/data at their reset values.
    task automatic test_random();
        wb_rec_t     mq[$];
        wb_rec_t     head;
        wb_rec_t     rec;
        logic [4:0]  expReg  = 5'd0;
        logic [31:0] expData = 32'd0;
        logic        expWe;
        logic [31:0] expMask;
        logic        av, mv, modelReady, accept, aluUse, anyValid;
        logic [4:0]  ar, mr;
        logic [31:0] ad, md;
        for (int c = 0; c < 1000; c++) begin
            av = 1'($urandom_range(0, 1));
            ar = 5'($urandom_range(0, 6));
            ad = $urandom;
            mv = ($urandom_range(0, 9) < 6);
            mr = 5'($urandom_range(0, 6));
            md = $urandom;
            applyStimulus(av, ar, ad, mv, mr, md);
            #1;
            modelReady = (mq.size() < 2);
            checks++; if (md_ready !== modelReady) begin failures++; $display("[TB] FAIL rnd_ready cyc=%0d got=%0b want=%0b", c, md_ready, modelReady); end
            accept   = mv && modelReady;
            aluUse   = av && (ar != 5'd0);
            expWe    = 1'b0;
            anyValid = 1'b0;
            foreach (mq[k]) if (mq[k].valid) anyValid = 1'b1;
            rec.valid = 1'b1;
            rec.rd    = mr;
            rec.data  = md;
            if (aluUse) begin
                expWe = 1'b1; expReg = ar; expData = ad;
                foreach (mq[k]) if (mq[k].rd == ar) mq[k].valid = 1'b0;
                if (accept && mr != 5'd0 && mr != ar) mq.push_back(rec);
            end else if (anyValid) begin
                head = mq.pop_front();
                if (head.valid) begin expWe = 1'b1; expReg = head.rd; expData = head.data; end
                if (accept && mr != 5'd0) mq.push_back(rec);
            end else begin
                if (mq.size() > 0) head = mq.pop_front();
                if (accept && mr != 5'd0) begin expWe = 1'b1; expReg = mr; expData = md; end
            end
            stepCycle();
            expMask = 32'd0;
            foreach (mq[k]) if (mq[k].valid) expMask = expMask | (32'd1 << mq[k].rd);
            checks++; if (wb_regWrite !== expWe) begin failures++; $display("[TB] FAIL rnd_we cyc=%0d got=%0b want=%0b", c, wb_regWrite, expWe); end
            checks++; if (wb_write_register !== expReg) begin failures++; $display("[TB] FAIL rnd_reg cyc=%0d got=%0d want=%0d", c, wb_write_register, expReg); end
            checks++; if (wb_write_data !== expData) begin failures++; $display("[TB] FAIL rnd_data cyc=%0d got=%h want=%h", c, wb_write_data, expData); end
            checks++; if (pending_mask !== expMask) begin failures++; $display("[TB] FAIL rnd_mask cyc=%0d got=%h want=%h", c, pending_mask, expMask); end
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_bypass();
        test_contention();
        test_waw_kill();
        test_full_simultaneous();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
